// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm clock sequencer: alarm-time edit, match, ring, snooze and buzzer gating
`timescale 1ns/1ps
module alarm_sequencer #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [4:0] hr_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    input  logic       alarm_en,
    input  logic       set_enable,
    input  logic       set_hr_or_min,
    input  logic       inc_pulse,
    input  logic       snooze_pulse,
    input  logic       stop_pulse,
    output logic [4:0] alarm_hr,
    output logic [5:0] alarm_min,
    output logic       ringing,
    output logic       buzzer,
    output logic [1:0] state
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ARMED  = 2'b01;
    localparam logic [1:0] RING   = 2'b10;
    localparam logic [1:0] SNOOZE = 2'b11;

    localparam logic [7:0] RING_LOAD   = 8'(RING_SECONDS);
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MINUTES * 60);

    logic [7:0] ring_cnt;
    logic [9:0] snooze_cnt;
    logic [1:0] state_nxt;
    logic [7:0] ring_nxt;
    logic [9:0] snooze_nxt;
    logic       buzzer_nxt;
    logic       match;
    logic       edit_ok;

    // The seconds==0 term stops a re-trigger after an early return to ARMED
    // within the matched minute; match uses the pre-increment alarm value.
    assign match   = tick_1hz && (hr_in == alarm_hr) && (min_in == alarm_min) && (sec_in == 6'd0);
    assign edit_ok = set_enable && inc_pulse && ((state == IDLE) || (state == ARMED));
    assign ringing = (state == RING);

    // Next-state logic: disarm beats stop, stop beats snooze, snooze beats ticks.
    always_comb begin
        state_nxt  = state;
        ring_nxt   = ring_cnt;
        snooze_nxt = snooze_cnt;
        buzzer_nxt = 1'b0;
        if (!alarm_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARMED;
                end
                ARMED: begin
                    if (match) begin
                        state_nxt = RING;
                        ring_nxt  = RING_LOAD;
                    end
                end
                RING: begin
                    if (stop_pulse) begin
                        state_nxt = ARMED;
                    end else if (snooze_pulse) begin
                        state_nxt  = SNOOZE;
                        snooze_nxt = SNOOZE_LOAD;
                    end else if (tick_1hz) begin
                        ring_nxt = ring_cnt - 8'd1;
                        if (ring_cnt == 8'd1) begin
                            state_nxt = ARMED;
                        end else begin
                            buzzer_nxt = ~buzzer;
                        end
                    end else begin
                        buzzer_nxt = buzzer;
                    end
                end
                default: begin
                    if (stop_pulse) begin
                        state_nxt = ARMED;
                    end else if (tick_1hz) begin
                        snooze_nxt = snooze_cnt - 10'd1;
                        if (snooze_cnt == 10'd1) begin
                            state_nxt = RING;
                            ring_nxt  = RING_LOAD;
                        end
                    end
                end
            endcase
        end
    end

    // Sequencer registers: state, ring/snooze counters and buzzer drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ring_cnt   <= 8'd0;
            snooze_cnt <= 10'd0;
            buzzer     <= 1'b0;
        end else begin
            state      <= state_nxt;
            ring_cnt   <= ring_nxt;
            snooze_cnt <= snooze_nxt;
            buzzer     <= buzzer_nxt;
        end
    end

    // Alarm time edit with independent hour and minute wrap (no carry).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hr  <= 5'd0;
            alarm_min <= 6'd0;
        end else if (edit_ok) begin
            if (!set_hr_or_min) begin
                alarm_hr <= (alarm_hr == 5'd23) ? 5'd0 : alarm_hr + 5'd1;
            end else begin
                alarm_min <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - self-checking bench for alarm_sequencer
`timescale 1ns/1ps
module tb_alarm_sequencer;

    localparam int RS = 60;
    localparam int SM = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [4:0] hr_in = 5'd0;
    logic [5:0] min_in = 6'd0;
    logic [5:0] sec_in = 6'd0;
    logic       alarm_en = 1'b0;
    logic       set_enable = 1'b0;
    logic       set_hr_or_min = 1'b0;
    logic       inc_pulse = 1'b0;
    logic       snooze_pulse = 1'b0;
    logic       stop_pulse = 1'b0;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic       ringing;
    logic       buzzer;
    logic [1:0] state;

    always #5 clk = ~clk;

    alarm_sequencer #(.RING_SECONDS(RS), .SNOOZE_MINUTES(SM)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .hr_in(hr_in), .min_in(min_in), .sec_in(sec_in),
        .alarm_en(alarm_en), .set_enable(set_enable), .set_hr_or_min(set_hr_or_min),
        .inc_pulse(inc_pulse), .snooze_pulse(snooze_pulse), .stop_pulse(stop_pulse),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .ringing(ringing),
        .buzzer(buzzer), .state(state)
    );

    int vectors = 0;
    int miscompares = 0;
    int t_sec = 0;

    // Reference model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing;
    // m_left counts seconds remaining in the current ring or snooze period.
    int   m_mode = 0;
    int   m_left = 0;
    int   m_ahr = 0;
    int   m_amin = 0;
    logic m_beep = 1'b0;
    wire  m_hit = tick_1hz && (int'(hr_in) == m_ahr) && (int'(min_in) == m_amin) && (sec_in == 6'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_left <= 0; m_ahr <= 0; m_amin <= 0; m_beep <= 1'b0;
        end else begin
            if (set_enable && inc_pulse && m_mode < 2) begin
                if (!set_hr_or_min) m_ahr <= (m_ahr + 1) % 24;
                else                m_amin <= (m_amin + 1) % 60;
            end
            if (!alarm_en) begin
                m_mode <= 0; m_beep <= 1'b0;
            end else if (m_mode == 0) begin
                m_mode <= 1;
            end else if (m_mode == 1) begin
                if (m_hit) begin m_mode <= 2; m_left <= RS; end
            end else if (m_mode == 2) begin
                if (stop_pulse) begin
                    m_mode <= 1; m_beep <= 1'b0;
                end else if (snooze_pulse) begin
                    m_mode <= 3; m_left <= SM * 60; m_beep <= 1'b0;
                end else if (tick_1hz) begin
                    if (m_left == 1) begin m_mode <= 1; m_beep <= 1'b0; end
                    else begin m_left <= m_left - 1; m_beep <= ~m_beep; end
                end
            end else begin
                if (stop_pulse) begin
                    m_mode <= 1;
                end else if (tick_1hz) begin
                    if (m_left == 1) begin m_mode <= 2; m_left <= RS; end
                    else m_left <= m_left - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        chk("state", int'(state), m_mode);
        chk("ringing", int'(ringing), (m_mode == 2) ? 1 : 0);
        chk("buzzer", int'(buzzer), int'(m_beep));
        chk("alarm_hr", int'(alarm_hr), m_ahr);
        chk("alarm_min", int'(alarm_min), m_amin);
    endtask

    task automatic drive_time();
        hr_in  = 5'(t_sec / 3600);
        min_in = 6'((t_sec / 60) % 60);
        sec_in = 6'(t_sec % 60);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        t_sec = h * 3600 + m * 60 + s;
        drive_time();
    endtask

    // Compare at the falling edge, let the rising edge consume the inputs,
    // then clear pulses and advance the clock time if a tick was consumed.
    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #2;
        if (tick_1hz) begin
            t_sec = (t_sec + 1) % 86400;
            drive_time();
        end
        tick_1hz = 1'b0; inc_pulse = 1'b0; snooze_pulse = 1'b0; stop_pulse = 1'b0;
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step();
    endtask

    task automatic inc(input logic sel);
        set_enable = 1'b1; set_hr_or_min = sel; inc_pulse = 1'b1;
        step();
    endtask

    task automatic count_ticks_in(input int mode, output int n);
        n = 0;
        while (int'(state) == mode && n < 1000) begin
            do_tick();
            n++;
        end
    endtask

    int n;

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_ringing", int'(ringing), 0);
        chk("reset_buzzer", int'(buzzer), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Set alarm to 07:30
        for (int i = 0; i < 7; i++) inc(1'b0);
        for (int i = 0; i < 30; i++) inc(1'b1);
        set_enable = 1'b0;
        step();
        chk("set_hr_7", int'(alarm_hr), 7);
        chk("set_min_30", int'(alarm_min), 30);
        alarm_en = 1'b1;
        step();
        chk("armed", int'(state), 1);

        // Match at 07:30:00, full ring length
        set_time(7, 29, 58);
        do_tick(); do_tick();
        chk("no_early_match", int'(state), 1);
        do_tick();
        chk("match_state", int'(state), 2);
        chk("match_ringing", int'(ringing), 1);
        chk("match_buzzer", int'(buzzer), 0);
        do_tick();
        chk("first_beep", int'(buzzer), 1);
        count_ticks_in(2, n);
        chk("ring_len", n + 1, RS);
        chk("ring_end_state", int'(state), 1);
        chk("ring_end_ringing", int'(ringing), 0);

        // Early stop inside the matched minute must not re-trigger
        set_time(7, 30, 0);
        do_tick();
        repeat (5) do_tick();
        stop_pulse = 1'b1;
        step();
        chk("stop_to_armed", int'(state), 1);
        repeat (10) do_tick();
        chk("no_retrigger", int'(state), 1);

        // Snooze: 300 ticks then ring again for a full period
        set_time(7, 30, 0);
        do_tick();
        repeat (3) do_tick();
        snooze_pulse = 1'b1;
        step();
        chk("snooze_state", int'(state), 3);
        chk("snooze_buzzer", int'(buzzer), 0);
        count_ticks_in(3, n);
        chk("snooze_len", n, SM * 60);
        chk("resnooze_ring", int'(state), 2);
        chk("resnooze_buzzer", int'(buzzer), 0);
        count_ticks_in(2, n);
        chk("ring_reload_len", n, RS);

        // Same-cycle snooze + stop, and disarm + stop
        set_time(7, 30, 0);
        do_tick();
        snooze_pulse = 1'b1; stop_pulse = 1'b1;
        step();
        chk("stop_beats_snooze", int'(state), 1);
        set_time(7, 30, 0);
        do_tick();
        alarm_en = 1'b0; stop_pulse = 1'b1;
        step();
        chk("disarm_beats_stop", int'(state), 0);
        alarm_en = 1'b1;
        step();

        // Edit wrap-around
        set_time(12, 0, 0);
        for (int i = 0; i < 16; i++) inc(1'b0);
        step();
        chk("hr_23", int'(alarm_hr), 23);
        inc(1'b0);
        step();
        chk("hr_wrap", int'(alarm_hr), 0);
        for (int i = 0; i < 5; i++) inc(1'b0);
        for (int i = 0; i < 29; i++) inc(1'b1);
        step();
        chk("min_59", int'(alarm_min), 59);
        inc(1'b1);
        step();
        chk("min_wrap", int'(alarm_min), 0);
        chk("min_wrap_no_carry", int'(alarm_hr), 5);
        set_enable = 1'b0;

        // inc_pulse ignored while ringing
        set_time(5, 0, 0);
        do_tick();
        chk("ring_0500", int'(state), 2);
        inc(1'b0); inc(1'b1);
        set_enable = 1'b0;
        step();
        chk("ring_inc_hr", int'(alarm_hr), 5);
        chk("ring_inc_min", int'(alarm_min), 0);

        // Reset pulse mid-snooze, no clock edge involved
        snooze_pulse = 1'b1;
        step();
        chk("pre_reset_snooze", int'(state), 3);
        #1 rst_n = 1'b0;
        #0.5;
        chk("async_state", int'(state), 0);
        chk("async_ringing", int'(ringing), 0);
        chk("async_buzzer", int'(buzzer), 0);
        chk("async_hr", int'(alarm_hr), 0);
        chk("async_min", int'(alarm_min), 0);
        #0.5 rst_n = 1'b1;
        alarm_en = 1'b0;
        repeat (3) step();
        chk("idle_after_reset", int'(state), 0);
        alarm_en = 1'b1;
        step();
        chk("rearm_after_reset", int'(state), 1);

        // Randomized phase against the model
        for (int c = 0; c < 6000; c++) begin
            if (alarm_en ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 9) == 0))
                alarm_en = ~alarm_en;
            tick_1hz      = 1'($urandom_range(0, 1));
            set_enable    = 1'($urandom_range(0, 1));
            set_hr_or_min = 1'($urandom_range(0, 1));
            inc_pulse     = ($urandom_range(0, 19) == 0);
            snooze_pulse  = ($urandom_range(0, 59) == 0);
            stop_pulse    = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 99) == 0) begin
                t_sec = (m_ahr * 3600 + m_amin * 60 + 86400 - int'($urandom_range(0, 2))) % 86400;
                drive_time();
            end
            step();
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter RING_SECONDS, default 60, SHALL set the ring duration in seconds (1..255).
REQ-002 Parameter SNOOZE_MINUTES, default 5, SHALL set the snooze duration in minutes (1..15).
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 tick_1hz  in  1  one-cycle pulse, once per second, aligned with the time counter update.
REQ-006 hr_in  in  5  current hour, binary 0..23.
REQ-007 min_in  in  6  current minute, binary 0..59.
REQ-008 sec_in  in  6  current second, binary 0..59.
REQ-009 alarm_en  in  1  level; 1 arms the alarm.
REQ-010 set_enable  in  1  level; 1 allows editing of the alarm time.
REQ-011 set_hr_or_min  in  1  edit field select: 0 = hour, 1 = minute.
REQ-012 inc_pulse  in  1  debounced one-cycle pulse that increments the selected field.
REQ-013 snooze_pulse  in  1  debounced one-cycle snooze request.
REQ-014 stop_pulse  in  1  debounced one-cycle stop request.
REQ-015 alarm_hr  out  5  stored alarm hour.
REQ-016 alarm_min  out  6  stored alarm minute.
REQ-017 ringing  out  1  high while in RING.
REQ-018 buzzer  out  1  1 Hz-gated beep drive.
REQ-019 state  out  2  encoding IDLE=00, ARMED=01, RING=10, SNOOZE=11.

Function
REQ-020 The FSM SHALL have exactly four states (IDLE, ARMED, RING, SNOOZE), each registered, and `state` SHALL reflect the current state with no combinational path from inputs.
REQ-021 IDLE: alarm_en=1 -> ARMED on the next edge.
REQ-022 ARMED: alarm_en=0 -> IDLE.
REQ-023 ARMED: a match SHALL move to RING, where a match is all of tick_1hz=1, hr_in=alarm_hr, min_in=alarm_min and sec_in=0; on entry, ring_cnt SHALL load RING_SECONDS.
REQ-024 RING: on each tick_1hz, ring_cnt SHALL decrement; a tick with ring_cnt=1 -> ARMED.
REQ-025 RING: stop_pulse -> ARMED.
REQ-026 RING: snooze_pulse -> SNOOZE, and snooze_cnt SHALL load SNOOZE_MINUTES*60 (10-bit).
REQ-027 SNOOZE: on each tick_1hz, snooze_cnt SHALL decrement; a tick with snooze_cnt=1 -> RING, with ring_cnt reloaded.
REQ-028 SNOOZE: stop_pulse -> ARMED.
REQ-029 Priority in any state SHALL be: alarm_en=0 (-> IDLE) > stop_pulse > snooze_pulse > tick-driven transitions.
REQ-030 snooze_pulse SHALL be ignored outside RING; stop_pulse SHALL be ignored in IDLE and ARMED.
REQ-031 Alarm edit: set_enable=1 and inc_pulse=1 SHALL increment the selected field, only in IDLE or ARMED.
REQ-032 Alarm edit wrap-around SHALL be hour 23 -> 0 and minute 59 -> 0, with no carry from minute into hour.
REQ-033 inc_pulse SHALL be ignored in RING and SNOOZE, and whenever set_enable=0.
REQ-034 Match evaluation SHALL use the alarm register value before any increment applied in the same cycle.
REQ-035 Latency: ringing SHALL rise one clk after the matching tick_1hz edge and fall one clk after the terminating event.
REQ-036 buzzer SHALL toggle on each tick_1hz while in RING, SHALL be 0 on RING entry, and SHALL be forced 0 in every other state.
REQ-037 Re-trigger: after a return to ARMED within the matched minute, no new match SHALL occur, because sec_in=0 is required.

Reset
REQ-038 rst_n=0 SHALL force, asynchronously: state=IDLE, alarm_hr=0, alarm_min=0, ring_cnt=0, snooze_cnt=0, ringing=0, buzzer=0.
REQ-039 Reset asserted mid-RING or mid-SNOOZE SHALL abort immediately to IDLE; the FSM SHALL not resume after release until alarm_en is sampled high.

Verification
REQ-040 Set hr field to 7 via 7 inc_pulses and min field to 30 via 30 inc_pulses, alarm_en=1; at 07:30:00 tick -> state=10, ringing=1, buzzer=0; RING_SECONDS ticks later -> state=01, ringing=0.
REQ-041 Ringing; snooze_pulse -> state=11, buzzer=0; after exactly 300 ticks (default) -> state=10, ring_cnt=60.
REQ-042 Same cycle snooze_pulse and stop_pulse in RING -> state=01; same cycle alarm_en=0 and stop_pulse -> state=00.
REQ-043 alarm_hr=23 with hr field inc_pulse -> alarm_hr=0; alarm_min=59 with min field inc_pulse -> alarm_min=0 and alarm_hr unchanged; inc_pulse during RING -> no change.
REQ-044 rst_n low for 1 ns mid-SNOOZE -> all outputs 0 without a clk edge; alarm_hr=0 and alarm_min=0.
